boot_run_sequencer: RTL

- Sequences bring-up of the pipelined RISC-V core.
- Accepts a word stream (valid/ready) and writes it through the core's external instruction-memory and data-memory ports.
- Then drives the core's enable for a programmed number of cycles, or until a halt request, and reports completion.
- Sits between the testbench/host stream source and the core's *_ext / *_ext_2 ports and enable input.

---
 rtl/boot_run_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/boot_run_sequencer.sv
// Core bring-up sequencer: streams words into instruction and data memory,
// then enables the core for a bounded number of cycles or until halt.
module boot_run_sequencer #(
  parameter int IMEM_DEPTH = 128,
  parameter int DMEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic [15:0] imem_words,
  input  logic [15:0] dmem_words,
  input  logic [31:0] run_len,
  input  logic        halt,
  input  logic        s_valid,
  input  logic [63:0] s_data,
  output logic        s_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] cycles
);

  // Stream handshake: a word moves on a clock edge when s_valid and s_ready
  // are both high; s_ready depends on state only, never on s_valid.
  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] imem_cnt, dmem_cnt, idx;
  logic [31:0] run_lim, cycles_inc;
  logic        idle_like, bad_len, xfer, last_i, last_d, limit_hit;

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign bad_len    = (32'(imem_words) > 32'(IMEM_DEPTH)) ||
                      (32'(dmem_words) > 32'(DMEM_DEPTH));
  assign xfer       = s_valid & s_ready;
  assign last_i     = (idx == imem_cnt - 16'd1);
  assign last_d     = (idx == dmem_cnt - 16'd1);
  assign cycles_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
  assign limit_hit  = cpu_enable && (run_lim != 32'd0) && (cycles_inc == run_lim);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (bad_len)                 state_nxt = IDLE;
          else if (imem_words != 16'd0) state_nxt = LOAD_I;
          else if (dmem_words != 16'd0) state_nxt = LOAD_D;
          else                          state_nxt = RUN;
        end
      end
      LOAD_I: if (xfer && last_i) state_nxt = (dmem_cnt != 16'd0) ? LOAD_D : RUN;
      LOAD_D: if (xfer && last_d) state_nxt = RUN;
      RUN:    if (halt || limit_hit) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // The core stays disabled while the final memory write pulse is still out,
  // so its first enabled cycle always follows the last write.
  always_comb begin
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_enable = 1'b0;
    case (state)
      LOAD_I, LOAD_D: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      RUN: begin
        busy       = 1'b1;
        cpu_enable = ~wen_ext & ~wen_ext_2;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      imem_cnt    <= '0;
      dmem_cnt    <= '0;
      run_lim     <= '0;
      idx         <= '0;
      err         <= 1'b0;
      cycles      <= '0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      if (idle_like && start) begin
        if (bad_len) begin
          err <= 1'b1;
        end else begin
          err      <= 1'b0;
          cycles   <= '0;
          imem_cnt <= imem_words;
          dmem_cnt <= dmem_words;
          run_lim  <= run_len;
          idx      <= '0;
        end
      end
      if (state == LOAD_I && xfer) begin
        wen_ext   <= 1'b1;
        addr_ext  <= {46'd0, idx, 2'b00};
        wdata_ext <= s_data[31:0];
        idx       <= last_i ? 16'd0 : idx + 16'd1;
      end
      if (state == LOAD_D && xfer) begin
        wen_ext_2   <= 1'b1;
        addr_ext_2  <= {45'd0, idx, 3'b000};
        wdata_ext_2 <= s_data;
        idx         <= last_d ? 16'd0 : idx + 16'd1;
      end
      if (cpu_enable) cycles <= cycles_inc;
    end
  end

endmodule
